// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: memory-mapped SPI master, mode 0, MSB first, one 8-bit
// full-duplex transfer per TXDATA write.
// Ports:
//   clk, reset        - system clock, asynchronous active-high reset
//   sel, we, re       - bus select, write strobe, read strobe (read side effects)
//   addr, wdata       - byte offset (0x0 TXDATA, 0x4 RXDATA, 0x8 STATUS, 0xC CLKDIV), write data
//   rdata             - combinational read mux, 0 for undecoded offsets
//   spi_cs, spi_sclk  - chip select (active-low), serial clock (idles low)
//   spi_mosi, spi_miso- serial data out / in
module spi_master_ctrl #(
  parameter logic [7:0] DIV_RESET = 8'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        spi_cs,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int unsigned DW = 8;
  localparam int unsigned BW = 3;
  localparam logic [3:0] A_TX  = 4'h0;
  localparam logic [3:0] A_RX  = 4'h4;
  localparam logic [3:0] A_ST  = 4'h8;
  localparam logic [3:0] A_DIV = 4'hC;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LEAD  = 3'd2,
    ST_TRAIL = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] clkdiv, div_lat, hcnt;
  logic [DW-1:0] tx_sh, rx_sh, rxbyte;
  logic [BW-1:0] bcnt;
  logic          rxv, ovr;
  logic          tx_wr, st_wr, div_wr, rx_rd;
  logic          busy, start, half_done;
  logic          rise, fall, gap_entry, bit_done;
  logic          unused_wdata;

  // Bus decode
  assign tx_wr  = sel && we && (addr == A_TX);
  assign st_wr  = sel && we && (addr == A_ST);
  assign div_wr = sel && we && (addr == A_DIV);
  assign rx_rd  = sel && re && (addr == A_RX);

  assign busy      = (state != ST_IDLE);
  assign start     = tx_wr && !busy;
  assign half_done = (hcnt == div_lat);
  assign unused_wdata = ^wdata[31:8];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next state and per-edge strobes
  always_comb begin
    state_n   = state;
    rise      = 1'b0;
    fall      = 1'b0;
    gap_entry = 1'b0;
    bit_done  = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_n = ST_SETUP;
      ST_SETUP: if (half_done) begin
                  state_n = ST_LEAD;
                  rise    = 1'b1;
                end
      ST_LEAD:  if (half_done) begin
                  state_n = ST_TRAIL;
                  fall    = 1'b1;
                end
      ST_TRAIL: if (half_done) begin
                  bit_done = 1'b1;
                  if (bcnt == BW'(7)) begin
                    state_n   = ST_GAP;
                    gap_entry = 1'b1;
                  end else begin
                    state_n = ST_LEAD;
                    rise    = 1'b1;
                  end
                end
      ST_GAP:   if (half_done) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Half-period and bit counters; divider is frozen for the whole transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt    <= '0;
      div_lat <= '0;
      bcnt    <= '0;
    end else begin
      if (start) begin
        hcnt    <= '0;
        div_lat <= clkdiv;
      end else if (busy) begin
        hcnt <= half_done ? '0 : hcnt + DW'(1);
      end
      if (start)         bcnt <= '0;
      else if (bit_done) bcnt <= bcnt + BW'(1);
    end
  end

  // Shift registers and received byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_sh  <= '0;
      rx_sh  <= '0;
      rxbyte <= '0;
    end else begin
      if (start)     tx_sh <= wdata[7:0];
      else if (fall) tx_sh <= {tx_sh[6:0], 1'b0};
      if (rise)      rx_sh <= {rx_sh[6:0], spi_miso};
      if (gap_entry) rxbyte <= rx_sh;
    end
  end

  // Control/status registers; RXV set beats a same-cycle RXDATA read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxv    <= 1'b0;
      ovr    <= 1'b0;
      clkdiv <= DIV_RESET;
    end else begin
      if (gap_entry)  rxv <= 1'b1;
      else if (rx_rd) rxv <= 1'b0;
      if (tx_wr && busy)          ovr <= 1'b1;
      else if (st_wr && wdata[2]) ovr <= 1'b0;
      if (div_wr) clkdiv <= wdata[7:0];
    end
  end

  // Pin registers, driven from the next state so they change with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spi_cs   <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      spi_cs   <= (state_n == ST_IDLE) || (state_n == ST_GAP);
      spi_sclk <= (state_n == ST_LEAD);
      if (start)          spi_mosi <= wdata[7];
      else if (fall)      spi_mosi <= tx_sh[6];
      else if (gap_entry) spi_mosi <= 1'b0;
    end
  end

  // Read mux
  always_comb begin
    rdata = '0;
    case (addr)
      A_RX:    rdata = 32'(rxbyte);
      A_ST:    rdata = 32'({ovr, rxv, busy});
      A_DIV:   rdata = 32'(clkdiv);
      default: rdata = '0;
    endcase
  end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Memory-mapped SPI master peripheral of the RV32I SoC. It sits between the CPU data bus and the board SPI pins `spi_cs`, `spi_sclk`, `spi_mosi` and `spi_miso`. Firmware writes one byte and the block runs one 8-bit full-duplex transfer: mode 0, MSB first. The byte shifted in from the slave is then held for the CPU to read.

## Interface

Parameters:
- `DIV_RESET`, default 3: reset value of CLKDIV. SCLK half-period is H = CLKDIV+1 clocks.

Ports:
- `clk` input 1: system clock, 125 MHz.
- `reset` input 1: asynchronous, active-high reset. One clock domain; reset is asynchronous and active-high.
- `sel` input 1: peripheral select from the address decoder.
- `we` input 1: write strobe, qualified by `sel`.
- `re` input 1: read strobe, qualified by `sel`. Used only for read side effects.
- `addr` input 4: byte offset. Only 0x0, 0x4, 0x8 and 0xC are decoded.
- `wdata` input 32: write data.
- `rdata` output 32: combinational read mux, 0 for undecoded offsets.
- `spi_cs` output 1: chip select, active-low.
- `spi_sclk` output 1: serial clock, idles low.
- `spi_mosi` output 1: master out.
- `spi_miso` input 1: master in. Changed by the slave on SCLK falling edges and on the CS falling edge.

## Operation

Registers:
- 0x0 TXDATA (W):
  - Write of `wdata[7:0]` while not busy loads the shift register and starts a transfer.
  - Write while busy is ignored and sets OVR.
- 0x4 RXDATA (R): `{24'b0, rxbyte}`. A read (`sel&re`) clears RXV.
- 0x8 STATUS (R/W): bit0 BUSY, bit1 RXV, bit2 OVR (sticky). Writing 1 to bit2 clears OVR; other bits are read-only.
- 0xC CLKDIV (R/W): 8 bits. Writable at any time. The value is latched into the active half-period at transfer start, so a write mid-transfer does not affect the transfer in progress.

State machine:
- IDLE: CS=1, SCLK=0. A TXDATA write moves to SETUP.
- SETUP: CS=0, MOSI=bit7. Lasts H clocks, then LEAD.
- LEAD: SCLK=1. Lasts H clocks. MISO is shifted into the LSB on the clock edge that raises SCLK. Then TRAIL.
- TRAIL: SCLK=0. MOSI moves to the next bit on the edge that lowers SCLK. Lasts H clocks. After the 8th TRAIL goes to GAP, otherwise back to LEAD.
- GAP: CS=1, MOSI=0. RXDATA is loaded and RXV set on the entry edge. Lasts H clocks, then IDLE.
- BUSY = (state ≠ IDLE).

Counters and conflicts:
- 3-bit bit counter and 8-bit half-period counter. Half-period counter counts 0..CLKDIV_latched, then wraps.
- CLKDIV=0 gives H=1 and SCLK = clk/2. CLKDIV=255 gives H=256.
- RXV set at GAP entry in the same cycle as an RXDATA read: set wins.
- TXDATA write in the cycle BUSY falls (last GAP cycle): treated as busy, so it is ignored and OVR is set.

Reset (any time, including mid-transfer), immediately:
- `spi_cs`=1, `spi_sclk`=0, `spi_mosi`=0.
- State IDLE, RXDATA=0, RXV=0, OVR=0, CLKDIV=`DIV_RESET`.
- No partial RXDATA update.

## Timing

- TXDATA write sampled at edge E0.
- CS falls at E0+1, BUSY=1 from E0+1.
- k-th SCLK rise (k=1..8) at E0+1+(2k−1)H; k-th fall at E0+1+2kH.
- CS rises, RXDATA valid, RXV=1 at E0+1+17H.
- BUSY=0 at E0+1+18H. Minimum CS-high time before the next transfer is H+1 clocks.
- Default H=4: SCLK 15.625 MHz, 72 clocks from write to BUSY clear.
- MOSI is stable ≥H clocks before every SCLK rise. MISO is sampled ≥H clocks after the slave's update point.

## Test plan

- Reset: assert `reset` for 3 µs mid-simulation, then release. Required: CS=1, SCLK=0, MOSI=0, STATUS=0x0, CLKDIV=3, RXDATA=0.
- Loopback (MISO tied to MOSI), write 0xA5, poll STATUS. Required:
  - Exactly 8 SCLK rises.
  - CS low 17×4 clocks.
  - RXDATA=0xA5, RXV=1.
  - RXV=0 after one RXDATA read.
- Slave model returns 0x3C while the master sends 0x81. Required: slave captured 0x81 on rising edges; RXDATA=0x3C.
- CLKDIV=0, write 0xFF. Required: SCLK period 2 clocks, BUSY high 18 clocks. Then CLKDIV=255, write 0x00: BUSY high 18×256 clocks.
- Write 0x11 then 0x22 while busy. Required: only 0x11 transmitted; OVR=1. Write STATUS bit2=1: OVR=0.
- Assert `reset` after the 3rd SCLK rise. Required: CS=1 and SCLK=0 immediately; RXV=0, RXDATA=0. A new transfer of 0x5A completes normally.
